// File: rtl/vga_code_loader.sv
// Colour-word feeder for the VGA stage: buffers half-word writes in a shadow
// register and commits them to the live code word only at the start of vsync.
module vga_code_loader #(
  parameter logic [23:0] RESET_CODE  = 24'hF0000F,
  parameter int unsigned SWAP_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_sel,
  input  logic [11:0] wr_color,
  input  logic        auto_swap,
  output logic [23:0] code,
  output logic        pending,
  output logic        frame_tick
);

  localparam int CNT_W = (SWAP_FRAMES > 1) ? $clog2(SWAP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWAP_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             vsync_d;
  logic             vs_fall;
  logic             wr_accept;
  logic             swap_due;
  logic             swap_pending;
  logic [CNT_W-1:0] frame_cnt;
  logic [23:0]      shadow;
  logic [23:0]      commit_value;

  assign vs_fall      = vsync_d & ~vsync;
  assign wr_ready     = (state != COMMIT);
  assign pending      = (state == PENDING);
  assign wr_accept    = wr_valid & wr_ready;
  assign swap_due     = auto_swap & vs_fall & (frame_cnt == CNT_LAST);
  assign commit_value = swap_pending ? {shadow[11:0], shadow[23:12]} : shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= vs_fall;
    end
  end

  // Frame counter only runs while auto-swap is enabled, so each enable starts a fresh period.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (!auto_swap) begin
      frame_cnt <= '0;
    end else if (vs_fall) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      swap_pending <= 1'b0;
    end else if (swap_due) begin
      swap_pending <= 1'b1;
    end else if (state == COMMIT) begin
      swap_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (vs_fall) begin
          if (swap_due || wr_accept) begin
            state_next = COMMIT;
          end
        end else if (wr_accept) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (vs_fall) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The commit rewrites the shadow too, so a swap persists into later edits.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RESET_CODE;
    end else if (state == COMMIT) begin
      shadow <= commit_value;
    end else if (wr_accept) begin
      if (wr_sel) begin
        shadow[11:0] <= wr_color;
      end else begin
        shadow[23:12] <= wr_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code <= RESET_CODE;
    end else if (state == COMMIT) begin
      code <= commit_value;
    end
  end

endmodule

// File: doc/vga_code_loader.md
Name: vga_code_loader

Overview:
Upstream feeder for the VGA timing/colour stage. It owns the 24-bit `code` word that stage displays: left-half colour in bits 23:12, right-half colour in bits 11:0, each 4:4:4 RGB. Colour writes arrive over a valid/ready port and go into a shadow register. The shadow is copied to `code` only at the start of vertical sync, so the picture never tears mid-frame. An optional auto-swap mode exchanges the two halves every SWAP_FRAMES frames.

Parameters:
RESET_CODE, 24'hF0000F, value of `code` and of the shadow register after reset.
SWAP_FRAMES, 60, number of frames between automatic half swaps; legal range 1..1023.

Ports:
clk  input  1  system/pixel clock, shared with the VGA stage.
rst  input  1  synchronous, active-high reset.
vsync  input  1  active-low vertical sync from the VGA stage, same clock domain.
wr_valid  input  1  colour write request.
wr_ready  output  1  block can accept a write this cycle.
wr_sel  input  1  0 = left half (code[23:12]), 1 = right half (code[11:0]).
wr_color  input  12  RGB 4:4:4 colour, {R,G,B}.
auto_swap  input  1  enables periodic half swap.
code  output  24  live colour word to the VGA stage.
pending  output  1  shadow holds writes not yet committed.
frame_tick  output  1  one-cycle pulse per detected vsync assertion.

Behaviour:
- Reset is synchronous and active-high, and overrides everything:
  - state=IDLE, shadow=RESET_CODE, code=RESET_CODE.
  - vsync_d=1, frame counter=0, frame_tick=0.
  - Uncommitted writes are discarded.
- Outputs decoded from state:
  - wr_ready = (state != COMMIT). It reads 1 during and after reset.
  - pending = (state == PENDING).
- Write acceptance: wr_valid & wr_ready on a clock edge. Shadow half selected by wr_sel takes wr_color on that edge; the other half is unchanged. Writes cost no cycles.
- vsync edge detect:
  - vsync_d is a registered copy of vsync.
  - vs_fall = vsync_d & ~vsync, combinational, high for exactly 1 cycle per frame.
- Frame counter (width = clog2 of SWAP_FRAMES, minimum 1):
  - Steps on vs_fall, wraps from SWAP_FRAMES-1 to 0.
  - Held at 0 while auto_swap=0.
  - swap_due = auto_swap & vs_fall & (counter == SWAP_FRAMES-1).
- swap_pending flag: set on swap_due, cleared in COMMIT.
- frame_tick is registered and equals vs_fall delayed one cycle.
- FSM:
  - IDLE -> PENDING on an accepted write with no vs_fall that cycle.
  - IDLE -> COMMIT on vs_fall & swap_due.
  - IDLE stays IDLE on vs_fall without swap_due.
  - PENDING -> COMMIT on vs_fall.
  - PENDING otherwise stays PENDING. Further writes overwrite shadow; last write wins.
  - IDLE with an accepted write and vs_fall in the same cycle goes directly to COMMIT.
  - COMMIT -> IDLE unconditionally after 1 cycle. No writes are accepted in COMMIT.
- COMMIT action:
  - Compute next = swap_pending ? {shadow[11:0], shadow[23:12]} : shadow.
  - Load code <= next and shadow <= next.
- Latency and ordering:
  - vs_fall detected in cycle N puts the FSM in COMMIT in cycle N+1; code shows the new value from cycle N+2.
  - A write accepted in cycle N (the vs_fall cycle) is included in that commit.
  - A swap and pending writes in the same frame: writes are applied to shadow first, then swapped.
- code changes only on a COMMIT edge or on reset; it holds otherwise.
- vsync stuck low produces a single vs_fall only; stuck high produces no commits and holds shadow writes indefinitely (pending=1).

Test Plan:
1. Reset: assert rst 2 cycles, release -> code=24'hF0000F, pending=0, wr_ready=1, frame_tick=0.
2. With vsync=1, write sel=0 color 12'h0F0 -> pending=1, code stays F0000F. Drive vsync 1->0 at cycle N -> frame_tick=1 at N+1, code=24'h0F000F at N+2, pending=0.
3. Same frame: write sel=1 12'h123, then sel=1 12'hABC, then sel=0 12'h456 -> after vsync fall code=24'h456ABC. wr_ready=0 exactly at N+1.
4. Write sel=1 12'h777 in the exact cycle vsync falls from IDLE -> code=24'hF00777 at N+2.
5. SWAP_FRAMES=2, auto_swap=1, code=24'h111222, no writes -> after 1st vsync fall code unchanged; after 2nd code=24'h222111; after 4th back to 24'h111222.
6. Write sel=0 12'hFFF (pending=1), assert rst before vsync fall -> code=F0000F, pending=0; next vsync fall leaves code F0000F.
